pwl_mac_bf16_pipe: RTL and testbench
====================================

PWL_MAC_BF16_PIPE -- requirements
Module: pwl_mac_bf16_pipe

Interface
REQ-001 The block SHALL have parameter EMIN, default -7, the lowest unbiased exponent with a table segment.
REQ-002 The block SHALL have parameter EMAX, default 6, the exclusive upper unbiased exponent bound; NENT = EMAX-EMIN segments per sign.
REQ-003 The block SHALL have parameter SUBSEG_BITS, default 0, range 0..3: the number of top mantissa bits selecting a sub-segment; table depth per sign = NENT*2^SUBSEG_BITS.
REQ-004 The block SHALL have derived parameter IW = clog2(NENT)+SUBSEG_BITS, the config index width.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1 / in_ready  output  1  input handshake.
REQ-008 x  input  16  BF16 operand: sign S = x[15], exponent E = x[14:7], mantissa M = x[6:0].
REQ-009 out_valid  output  1 / out_ready  input  1  output handshake.
REQ-010 y  output  16  BF16 result.
REQ-011 cfg_w_en  input  1  table write strobe.
REQ-012 cfg_sgn  input  1  table sign half.
REQ-013 cfg_idx  input  IW  table entry.
REQ-014 cfg_base  input  16  base value.
REQ-015 cfg_offset  input  16  slope value.

Function
REQ-016 Storage SHALL be BASE[2][NENT*2^SUBSEG_BITS] and OFF[2][NENT*2^SUBSEG_BITS], 16 bits each; cfg_w_en=1 writes both at [cfg_sgn][cfg_idx] on the clock edge.
REQ-017 A write with cfg_idx >= NENT*2^SUBSEG_BITS SHALL be ignored.
REQ-018 Define LO = 127+EMIN and HI = 127+EMAX; segment index = {E-LO, M[6:7-SUBSEG_BITS]}, and fractional part F = M[6-SUBSEG_BITS:0] (FW = 7-SUBSEG_BITS bits).
REQ-019 In-range result SHALL be approx = (BASE + ((F*OFF) >> FW))[15:0], using a full-width product and a modulo-2^16 sum with no saturation.
REQ-020 NaN (E=255, M!=0) SHALL produce y = 16'h7FC0.
REQ-021 Otherwise, E >= HI SHALL produce y = 16'hFF80 if S=1, else 16'h7F80.
REQ-022 Otherwise, E < LO SHALL produce y = 16'h0000 regardless of sign.
REQ-023 Otherwise, y SHALL be approx.
REQ-024 The pipeline SHALL have two stages. S1 captures x, the range flags, and BASE/OFF read at acceptance. S2 captures the final y.
REQ-025 Latency SHALL be exactly 2 cycles from an accepted input (in_valid&in_ready) to out_valid when out_ready stays 1; throughput is 1 per cycle.
REQ-026 Stage-advance rule: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv; out_valid = s2_valid.
REQ-027 While out_valid=1 and out_ready=0, y and out_valid SHALL hold stable; no sample is dropped, duplicated or reordered.
REQ-028 A table write in the same cycle as an acceptance SHALL NOT affect that sample (it sees old contents); samples accepted on later cycles see the new contents.
REQ-029 Samples already in S1/S2 SHALL be unaffected by later table writes.
REQ-030 in_ready SHALL depend only on internal state and out_ready, never on in_valid.

Reset
REQ-031 While rst_n=0 at a clock edge: s1_valid=s2_valid=0, out_valid=0, y=16'h0000, and all BASE/OFF entries cleared to 0.
REQ-032 cfg_w_en and in_valid SHALL be ignored while rst_n=0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.
REQ-034 Reset asserted mid-operation SHALL discard in-flight samples with no output emitted for them.

Verification (defaults EMIN=-7, EMAX=6, SUBSEG_BITS=0)
REQ-035 Write BASE[0][7]=3F00, OFF[0][7]=0100, then x=3F80 -> y=3F00; then x=3FC0 -> y=3F80; each with out_valid exactly 2 cycles after acceptance.
REQ-036 x=4300 -> y=7F80; x=C300 -> y=FF80; x=3B80 -> y=0000; x=7FC1 -> y=7FC0; x=7F80 -> y=7F80.
REQ-037 Stream x=3F80,3FC0,3F80 back-to-back with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, y holds 3F00; on out_ready=1 -> outputs 3F00,3F80,3F00 in order, none lost.
REQ-038 Write BASE[0][7]=4000 in the same cycle x=3F80 is accepted -> that output is 3F00; next x=3F80 -> 4000.
REQ-039 SUBSEG_BITS=1: write BASE[0][15]=1234, OFF[0][15]=0000; x=3FC0 -> y=1234; write to idx 26 is ignored.
REQ-040 Assert rst_n=0 for 1 cycle with 2 samples in flight -> out_valid=0, y=0000, no stale output; x=3F80 afterwards -> y=0000 (table cleared).

Source files
------------

// File: rtl/pwl_mac_bf16_pipe.sv
// ---------------------------------------------------------------------------
// pwl_mac_bf16_pipe
//
// Piecewise-linear function evaluator for BF16 operands. A programmable table
// holds one (base, slope) pair per exponent segment, optionally split into
// 2^SUBSEG_BITS sub-segments by the top mantissa bits. Each sample computes
// base + (frac * slope) >> FW in a two-stage valid/ready pipeline. NaN,
// overflow and underflow inputs produce fixed results.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_n_i        synchronous active-low reset (also clears the table)
//   in_valid_i     input sample valid
//   in_ready_o     pipeline can take a sample this cycle
//   x_i[15:0]      BF16 operand
//   out_valid_o    result valid
//   out_ready_i    downstream takes the result this cycle
//   y_o[15:0]      BF16 result
//   cfg_w_en_i     table write strobe
//   cfg_sgn_i      table half (operand sign) to write
//   cfg_idx_i      table entry to write
//   cfg_base_i     base value to write
//   cfg_offset_i   slope value to write
// ---------------------------------------------------------------------------
module pwl_mac_bf16_pipe #(
    parameter int EMIN        = -7,
    parameter int EMAX        = 6,
    parameter int SUBSEG_BITS = 0,
    localparam int NENT       = EMAX - EMIN,
    localparam int IW         = $clog2(NENT) + SUBSEG_BITS
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [15:0]   x_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [15:0]   y_o,
    input  logic          cfg_w_en_i,
    input  logic          cfg_sgn_i,
    input  logic [IW-1:0] cfg_idx_i,
    input  logic [15:0]   cfg_base_i,
    input  logic [15:0]   cfg_offset_i
);

    localparam int DEPTH = NENT << SUBSEG_BITS;
    localparam int FW    = 7 - SUBSEG_BITS;
    localparam int LO    = 127 + EMIN;
    localparam int HI    = 127 + EMAX;

    logic [15:0]   baseMem_q [2][DEPTH];
    logic [15:0]   offMem_q  [2][DEPTH];

    logic          s1Valid_q;
    logic          s1Sign_q;
    logic [6:0]    s1Mant_q;
    logic          s1Nan_q;
    logic          s1Hi_q;
    logic          s1Lo_q;
    logic [15:0]   s1Base_q;
    logic [15:0]   s1Off_q;

    logic          s2Valid_q;
    logic [15:0]   y_q;
    logic [15:0]   y_d;

    logic          s1Adv;
    logic          s2Adv;
    logic          cfgInRange;

    logic [7:0]    inExp;
    logic [6:0]    inMant;
    logic          inNan;
    logic          inHi;
    logic          inLo;
    logic [31:0]   segOff;
    logic [IW-1:0] readIdx;
    logic [15:0]   readBase;
    logic [15:0]   readOff;

    logic [6:0]    s1Frac;
    logic [22:0]   product;
    logic [15:0]   approx;

    // Handshake: a stage may load when it is empty or its consumer is moving.
    // in_ready deliberately never looks at in_valid.
    assign s2Adv       = !s2Valid_q || out_ready_i;
    assign s1Adv       = !s1Valid_q || s2Adv;
    assign in_ready_o  = s1Adv;
    assign out_valid_o = s2Valid_q;
    assign y_o         = y_q;

    // Writes past the populated depth are dropped (the index field may be
    // wider than the table when NENT is not a power of two).
    assign cfgInRange = {1'b0, cfg_idx_i} < (IW+1)'(DEPTH);

    // Classify the incoming operand and look up its segment. The table read
    // is combinational from the registered contents, so a write landing on
    // the same edge as acceptance is not seen by that sample.
    always_comb begin
        inExp    = x_i[14:7];
        inMant   = x_i[6:0];
        inNan    = (inExp == 8'hFF) && (inMant != 7'd0);
        inHi     = int'(inExp) >= HI;
        inLo     = int'(inExp) < LO;
        segOff   = 32'(int'(inExp) - LO);
        readIdx  = IW'((segOff << SUBSEG_BITS) | (32'(inMant) >> FW));
        readBase = 16'h0000;
        readOff  = 16'h0000;
        if (!inHi && !inLo) begin
            readBase = baseMem_q[x_i[15]][readIdx];
            readOff  = offMem_q[x_i[15]][readIdx];
        end
    end

    // Coefficient table: cleared by reset, written one (base, slope) pair
    // at a time.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    baseMem_q[s][i] <= 16'h0000;
                    offMem_q[s][i]  <= 16'h0000;
                end
            end
        end else if (cfg_w_en_i && cfgInRange) begin
            baseMem_q[cfg_sgn_i][cfg_idx_i] <= cfg_base_i;
            offMem_q[cfg_sgn_i][cfg_idx_i]  <= cfg_offset_i;
        end
    end

    // Stage 1 holds the operand fields, range flags and the coefficients as
    // they were at acceptance, so later table writes cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1Valid_q <= 1'b0;
            s1Sign_q  <= 1'b0;
            s1Mant_q  <= 7'd0;
            s1Nan_q   <= 1'b0;
            s1Hi_q    <= 1'b0;
            s1Lo_q    <= 1'b0;
            s1Base_q  <= 16'h0000;
            s1Off_q   <= 16'h0000;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1Sign_q <= x_i[15];
                s1Mant_q <= inMant;
                s1Nan_q  <= inNan;
                s1Hi_q   <= inHi;
                s1Lo_q   <= inLo;
                s1Base_q <= readBase;
                s1Off_q  <= readOff;
            end
        end
    end

    // Interpolation and special-case selection. The product is kept at full
    // width and the final sum wraps modulo 2^16 without saturation.
    always_comb begin
        s1Frac  = s1Mant_q & 7'((1 << FW) - 1);
        product = 23'(s1Frac) * 23'(s1Off_q);
        approx  = s1Base_q + 16'(product >> FW);
        y_d     = approx;
        if (s1Nan_q) begin
            y_d = 16'h7FC0;
        end else if (s1Hi_q) begin
            y_d = s1Sign_q ? 16'hFF80 : 16'h7F80;
        end else if (s1Lo_q) begin
            y_d = 16'h0000;
        end
    end

    // Stage 2 is the output register; it holds while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s2Valid_q <= 1'b0;
            y_q       <= 16'h0000;
        end else if (s2Adv) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                y_q <= y_d;
            end
        end
    end

endmodule

// File: tb/tb_pwl_mac_bf16_pipe.sv
// ---------------------------------------------------------------------------
// tb_pwl_mac_bf16_pipe
//
// Drives two instances in lock-step: A with the default parameters and B with
// SUBSEG_BITS=1. A driver pushes expected results into per-instance queues
// at acceptance; monitors pop and compare whenever a result is handed off.
// ---------------------------------------------------------------------------
module tb_pwl_mac_bf16_pipe;

    typedef struct {
        logic [15:0] y;
        int          acc;
        bit          lat;
    } expT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        outReady;
    logic [15:0] x;
    logic        cfgWEn;
    logic        cfgSgn;
    logic [4:0]  cfgIdx;
    logic [15:0] cfgBase;
    logic [15:0] cfgOff;

    logic        inReadyA, outValidA, inReadyB, outValidB;
    logic [15:0] yA, yB;

    logic [15:0] mBaseA [2][13];
    logic [15:0] mOffA  [2][13];
    logic [15:0] mBaseB [2][26];
    logic [15:0] mOffB  [2][26];

    expT         qA[$];
    expT         qB[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycle      = 0;

    bit          useA = 0, useB = 0, latCheck = 0;
    logic [15:0] wantA = '0, wantB = '0;

    pwl_mac_bf16_pipe dutA (
        .clk_i(clk), .rst_n_i(rstN),
        .in_valid_i(inValid), .in_ready_o(inReadyA), .x_i(x),
        .out_valid_o(outValidA), .out_ready_i(outReady), .y_o(yA),
        .cfg_w_en_i(cfgWEn), .cfg_sgn_i(cfgSgn), .cfg_idx_i(cfgIdx[3:0]),
        .cfg_base_i(cfgBase), .cfg_offset_i(cfgOff)
    );

    pwl_mac_bf16_pipe #(.SUBSEG_BITS(1)) dutB (
        .clk_i(clk), .rst_n_i(rstN),
        .in_valid_i(inValid), .in_ready_o(inReadyB), .x_i(x),
        .out_valid_o(outValidB), .out_ready_i(outReady), .y_o(yB),
        .cfg_w_en_i(cfgWEn), .cfg_sgn_i(cfgSgn), .cfg_idx_i(cfgIdx),
        .cfg_base_i(cfgBase), .cfg_offset_i(cfgOff)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Table index for the default range (exponents 120..132), -1 outside.
    function automatic int refIdx(input logic [15:0] xv, input int ssb);
        int e, m;
        e = int'(xv[14:7]);
        m = int'(xv[6:0]);
        if (e < 120 || e >= 133) return -1;
        return (e - 120) * (1 << ssb) + m / (1 << (7 - ssb));
    endfunction

    // Expected BF16 result from the segment rules with plain arithmetic.
    function automatic logic [15:0] refY(input logic [15:0] xv, input int ssb,
                                         input logic [15:0] b, input logic [15:0] o);
        int     e, m, fw, f;
        longint p;
        e  = int'(xv[14:7]);
        m  = int'(xv[6:0]);
        fw = 7 - ssb;
        if (e == 255 && m != 0) return 16'h7FC0;
        if (e >= 133) return xv[15] ? 16'hFF80 : 16'h7F80;
        if (e < 120) return 16'h0000;
        f = m % (1 << fw);
        p = longint'(f) * longint'(o);
        return 16'((longint'(b) + p / (1 << fw)) % 65536);
    endfunction

    function automatic logic [15:0] modelA(input logic [15:0] xv);
        int i;
        i = refIdx(xv, 0);
        if (i < 0) return refY(xv, 0, 16'h0, 16'h0);
        return refY(xv, 0, mBaseA[xv[15]][i], mOffA[xv[15]][i]);
    endfunction

    function automatic logic [15:0] modelB(input logic [15:0] xv);
        int i;
        i = refIdx(xv, 1);
        if (i < 0) return refY(xv, 1, 16'h0, 16'h0);
        return refY(xv, 1, mBaseB[xv[15]][i], mOffB[xv[15]][i]);
    endfunction

    function automatic logic [15:0] randX();
        logic [15:0] specials [5];
        specials = '{16'h7FC1, 16'h7F80, 16'hFF80, 16'h0000, 16'h8000};
        if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 4)];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(117, 136)), 7'($urandom_range(0, 127))};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    task automatic noteFail(input string name, input string got, input string want);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cycle);
    endtask

    // One clock of stimulus: at the falling edge decide what the coming
    // rising edge accepts, log expectations from the model's current table,
    // then apply any table write or reset to the model.
    task automatic stepCycle(output bit accA);
        bit  accB;
        expT e;
        @(negedge clk);
        accA = rstN && inValid && inReadyA;
        accB = rstN && inValid && inReadyB;
        if (accA) begin
            e.y = useA ? wantA : modelA(x);
            e.acc = cycle;
            e.lat = latCheck && outReady;
            qA.push_back(e);
        end
        if (accB) begin
            e.y = useB ? wantB : modelB(x);
            e.acc = cycle;
            e.lat = 1'b0;
            qB.push_back(e);
        end
        if (!rstN) begin
            qA.delete();
            qB.delete();
            foreach (mBaseA[s, i]) begin mBaseA[s][i] = '0; mOffA[s][i] = '0; end
            foreach (mBaseB[s, i]) begin mBaseB[s][i] = '0; mOffB[s][i] = '0; end
        end else if (cfgWEn) begin
            if (cfgIdx[3:0] < 4'd13) begin
                mBaseA[cfgSgn][cfgIdx[3:0]] = cfgBase;
                mOffA[cfgSgn][cfgIdx[3:0]]  = cfgOff;
            end
            if (cfgIdx < 5'd26) begin
                mBaseB[cfgSgn][cfgIdx] = cfgBase;
                mOffB[cfgSgn][cfgIdx]  = cfgOff;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) stepCycle(acc);
    endtask

    task automatic writeCfg(input logic s, input logic [4:0] idx, input logic [15:0] b, input logic [15:0] o);
        bit acc;
        cfgWEn = 1'b1; cfgSgn = s; cfgIdx = idx; cfgBase = b; cfgOff = o;
        stepCycle(acc);
        cfgWEn = 1'b0;
    endtask

    // Present one sample until A accepts it; B runs in lock-step.
    task automatic applyStimulus(input logic [15:0] xv, input bit useIt, input logic [15:0] want);
        bit acc;
        acc = 1'b0;
        useA = useIt; wantA = want;
        inValid = 1'b1; x = xv;
        for (int n = 0; n < 20 && !acc; n++) stepCycle(acc);
        inValid = 1'b0;
        useA = 1'b0;
        if (!acc) noteFail("acceptTimeout", "no accept", "accept within 20 cycles");
    endtask

    // Monitor for A: compares each handed-off result, checks that a stalled
    // result holds, and measures latency for samples that never stalled.
    bit          stalledA = 0;
    logic [15:0] heldA;
    int          sinceA = 0;
    always @(negedge clk) begin
        expT e;
        if (!rstN) begin
            stalledA = 0;
        end else begin
            if (stalledA) begin
                checkOutput("holdValidA", {15'd0, outValidA}, 16'd1);
                checkOutput("holdYA", yA, heldA);
            end
            if (outValidA && !stalledA) sinceA = cycle;
            if (outValidA && outReady) begin
                if (qA.size() == 0) begin
                    noteFail("unexpectedOutA", $sformatf("%h", yA), "no output");
                end else begin
                    e = qA.pop_front();
                    checkOutput("yA", yA, e.y);
                    if (e.lat) checkOutput("latencyA", 16'(sinceA - e.acc), 16'd2);
                end
            end
            stalledA = outValidA && !outReady;
            heldA = yA;
        end
    end

    // Monitor for B: result values only.
    always @(negedge clk) begin
        expT e;
        if (rstN && outValidB && outReady) begin
            if (qB.size() == 0) begin
                noteFail("unexpectedOutB", $sformatf("%h", yB), "no output");
            end else begin
                e = qB.pop_front();
                checkOutput("yB", yB, e.y);
            end
        end
    end

    initial begin
        bit          acc;
        logic [15:0] dirX [5];
        logic [15:0] dirY [5];
        dirX = '{16'h4300, 16'hC300, 16'h3B80, 16'h7FC1, 16'h7F80};
        dirY = '{16'h7F80, 16'hFF80, 16'h0000, 16'h7FC0, 16'h7F80};

        rstN = 1'b0; inValid = 1'b1; outReady = 1'b1; x = 16'h3F80;
        cfgWEn = 1'b1; cfgSgn = 1'b0; cfgIdx = 5'd7; cfgBase = 16'h1111; cfgOff = 16'h2222;
        stepCycle(acc);
        stepCycle(acc);
        rstN = 1'b1; cfgWEn = 1'b0; inValid = 1'b0;
        checkOutput("rstOutValid", {15'd0, outValidA}, 16'd0);
        checkOutput("rstY", yA, 16'h0000);
        checkOutput("rstInReady", {15'd0, inReadyA}, 16'd1);
        latCheck = 1'b1;
        applyStimulus(16'h3F80, 1'b1, 16'h0000);

        $display("[TB] basic interpolation");
        writeCfg(1'b0, 5'd7, 16'h3F00, 16'h0100);
        applyStimulus(16'h3F80, 1'b1, 16'h3F00);
        applyStimulus(16'h3FC0, 1'b1, 16'h3F80);

        $display("[TB] special values");
        for (int i = 0; i < 5; i++) applyStimulus(dirX[i], 1'b1, dirY[i]);
        idle(3);

        $display("[TB] back-pressure");
        outReady = 1'b0;
        applyStimulus(16'h3F80, 1'b1, 16'h3F00);
        applyStimulus(16'h3FC0, 1'b1, 16'h3F80);
        checkOutput("stallInReady", {15'd0, inReadyA}, 16'd0);
        checkOutput("stallOutValid", {15'd0, outValidA}, 16'd1);
        checkOutput("stallY", yA, 16'h3F00);
        useA = 1'b1; wantA = 16'h3F00; inValid = 1'b1; x = 16'h3F80;
        stepCycle(acc);
        stepCycle(acc);
        outReady = 1'b1;
        if (!acc) applyStimulus(16'h3F80, 1'b1, 16'h3F00);
        inValid = 1'b0; useA = 1'b0;
        idle(4);

        $display("[TB] write during acceptance");
        cfgWEn = 1'b1; cfgSgn = 1'b0; cfgIdx = 5'd7; cfgBase = 16'h4000; cfgOff = 16'h0100;
        applyStimulus(16'h3F80, 1'b1, 16'h3F00);
        cfgWEn = 1'b0;
        applyStimulus(16'h3F80, 1'b1, 16'h4000);

        $display("[TB] sub-segments");
        writeCfg(1'b0, 5'd15, 16'h1234, 16'h0000);
        useB = 1'b1; wantB = 16'h1234;
        applyStimulus(16'h3FC0, 1'b0, 16'h0000);
        writeCfg(1'b0, 5'd26, 16'hABCD, 16'h0001);
        applyStimulus(16'h3FC0, 1'b0, 16'h0000);
        useB = 1'b0;
        idle(3);

        $display("[TB] reset with samples in flight");
        applyStimulus(16'h3F80, 1'b0, 16'h0000);
        applyStimulus(16'h3FC0, 1'b0, 16'h0000);
        outReady = 1'b0; rstN = 1'b0;
        cfgWEn = 1'b1; cfgSgn = 1'b0; cfgIdx = 5'd7; cfgBase = 16'h5555; cfgOff = 16'h5555;
        inValid = 1'b1; x = 16'h3F80;
        stepCycle(acc);
        rstN = 1'b1; cfgWEn = 1'b0; inValid = 1'b0; outReady = 1'b1;
        checkOutput("midRstOutValid", {15'd0, outValidA}, 16'd0);
        checkOutput("midRstY", yA, 16'h0000);
        idle(4);
        applyStimulus(16'h3F80, 1'b1, 16'h0000);

        $display("[TB] random traffic");
        latCheck = 1'b0;
        for (int n = 0; n < 300; n++) begin
            inValid  = ($urandom_range(0, 9) < 8);
            x        = randX();
            outReady = ($urandom_range(0, 9) < 7);
            cfgWEn   = ($urandom_range(0, 9) == 0);
            cfgSgn   = 1'($urandom_range(0, 1));
            cfgIdx   = 5'($urandom_range(0, 31));
            cfgBase  = 16'($urandom);
            cfgOff   = 16'($urandom);
            stepCycle(acc);
        end
        cfgWEn = 1'b0; inValid = 1'b0; outReady = 1'b1;
        idle(3);
        latCheck = 1'b1;
        for (int n = 0; n < 80; n++) begin
            inValid = ($urandom_range(0, 9) < 8);
            x       = randX();
            stepCycle(acc);
        end
        inValid = 1'b0;

        for (int n = 0; n < 30 && (qA.size() != 0 || qB.size() != 0); n++) stepCycle(acc);
        if (qA.size() != 0) noteFail("drainA", $sformatf("%0d pending", qA.size()), "0 pending");
        if (qB.size() != 0) noteFail("drainB", $sformatf("%0d pending", qB.size()), "0 pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
